// File: rtl/data_mem_pkg.sv
// Purpose: shared types and widths for the fixed-latency data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

endpackage : data_mem_pkg

// File: rtl/byte_ram.sv
// Purpose: single-port synchronous RAM, per-byte write enables, registered read.
// Latency: read data appears the cycle after an enabled read edge.
// Backpressure: none; every enabled cycle performs its access.
//
// Ports:
//   clk_i  - clock
//   rst_i  - async active-low reset, clears only the read-data register
//   en_i   - perform an access on this edge
//   we_i   - 1 = write lanes selected by be_i, 0 = read whole word
//   be_i   - per-byte write mask
//   addr_i - word index
//   wd_i   - write data
//   rd_o   - registered read data, holds until the next read
module byte_ram
    import data_mem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [BE_W-1:0]          be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WORD_W-1:0]        wd_i,
    output logic [WORD_W-1:0]        rd_o
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd;

    // Array has no reset so it maps onto plain RAM macros / block RAM.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) begin
                    r_mem[addr_i][8*i +: 8] <= wd_i[8*i +: 8];
                end
            end
        end
    end

    // Output register only updates on reads, so writes leave the last
    // read result visible.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd <= '0;
        end else if (en_i && !we_i) begin
            r_rd <= r_mem[addr_i];
        end
    end

    assign rd_o = r_rd;

endmodule : byte_ram

// File: rtl/lat_data_mem.sv
// Purpose: word-addressed data memory with fixed LATENCY and req/ready handshake.
// Latency: ready_o pulses exactly LATENCY cycles after the accepting cycle.
// Backpressure: one request in flight; new requests accepted only in IDLE.
//
// Ports:
//   clk_i          - clock
//   rst_i          - async active-low reset
//   mem_req_i      - request valid, held with its fields until ready_o
//   write_enable_i - 1 = write, 0 = read
//   byte_enable_i  - write lane mask (ignored on reads)
//   addr_i         - byte address, word index = addr_i[AW+1:2]
//   write_data_i   - lane-aligned write data
//   read_data_o    - last read result, valid with ready_o for a read
//   ready_o        - one-cycle completion pulse
module lat_data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_i,
    input  logic              write_enable_i,
    input  logic [BE_W-1:0]   byte_enable_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] write_data_i,
    output logic [WORD_W-1:0] read_data_o,
    output logic              ready_o
);

    localparam int  AW    = $clog2(DEPTH_WORDS);
    localparam int  CNT_W = $clog2(LATENCY + 1);
    // With a single cycle of latency the array is accessed in the accepting
    // cycle itself, so the live request fields feed the RAM directly.
    localparam bit  LIVE  = (LATENCY == 1);

    dmem_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ready;

    logic              r_we;
    logic [BE_W-1:0]   r_be;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wd;

    logic              w_accept;
    logic              w_access;
    logic              w_we;
    logic [BE_W-1:0]   w_be;
    logic [AW-1:0]     w_idx;
    logic [WORD_W-1:0] w_wd;
    logic              w_addr_unused;

    // Byte offset and bits above the array size are don't-care: addresses wrap.
    assign w_addr_unused = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign w_accept = (r_state == IDLE) && mem_req_i;

    always_comb begin
        w_access = 1'b0;
        w_we     = r_we;
        w_be     = r_be;
        w_idx    = r_idx;
        w_wd     = r_wd;
        if (LIVE) begin
            w_access = w_accept;
            w_we     = write_enable_i;
            w_be     = byte_enable_i;
            w_idx    = addr_i[AW+1:2];
            w_wd     = write_data_i;
        end else begin
            w_access = (r_state == BUSY) && (r_cnt == CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_idx   <= '0;
            r_wd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (mem_req_i) begin
                        r_we  <= write_enable_i;
                        r_be  <= byte_enable_i;
                        r_idx <= addr_i[AW+1:2];
                        r_wd  <= write_data_i;
                        if (LIVE) begin
                            r_state <= DONE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // A request present here is deliberately ignored; it is
                    // picked up on the following IDLE cycle.
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    byte_ram #(
        .DEPTH     (DEPTH_WORDS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (w_access),
        .we_i   (w_we),
        .be_i   (w_be),
        .addr_i (w_idx),
        .wd_i   (w_wd),
        .rd_o   (read_data_o)
    );

    assign ready_o = r_ready;

endmodule : lat_data_mem

// File: tb/tb_lat_data_mem.sv
module tb_lat_data_mem;

    logic        clk;
    logic        rst_n;
    logic        sel;       // 0 -> LATENCY=2 instance, 1 -> LATENCY=1 instance
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;

    logic        a_req, b_req;
    logic [31:0] a_rd, b_rd;
    logic        a_ready, b_ready;
    logic [31:0] rd;
    logic        ready;

    int n_assert = 0;
    int n_fail   = 0;

    assign a_req = req & ~sel;
    assign b_req = req & sel;
    assign rd    = sel ? b_rd : a_rd;
    assign ready = sel ? b_ready : a_ready;

    lat_data_mem #(.DEPTH_WORDS(1024), .LATENCY(2), .INIT_FILE("")) u_a (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .mem_req_i      (a_req),
        .write_enable_i (we),
        .byte_enable_i  (be),
        .addr_i         (addr),
        .write_data_i   (wd),
        .read_data_o    (a_rd),
        .ready_o        (a_ready)
    );

    lat_data_mem #(.DEPTH_WORDS(1024), .LATENCY(1), .INIT_FILE("")) u_b (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .mem_req_i      (b_req),
        .write_enable_i (we),
        .byte_enable_i  (be),
        .addr_i         (addr),
        .write_data_i   (wd),
        .read_data_o    (b_rd),
        .ready_o        (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete request on the selected instance; checks ready timing
    // and, for reads, the data returned with ready.
    task automatic xact(input logic s, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input string tag);
        int lat;
        lat  = s ? 1 : 2;
        sel  = s;
        we   = w;
        be   = b;
        addr = a;
        wd   = d;
        req  = 1'b1;
        chk({31'b0, ready}, 32'h0, {tag, "_rdy_T"});
        for (int k = 1; k <= lat; k++) begin
            step();
            chk({31'b0, ready}, (k == lat) ? 32'h1 : 32'h0, $sformatf("%s_rdy_T+%0d", tag, k));
        end
        chk(rd, exp_rd, {tag, "_rd"});
        req = 1'b0;
        step();
        chk({31'b0, ready}, 32'h0, {tag, "_rdy_after"});
    endtask

    initial begin
        sel   = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = 32'h0;
        wd    = 32'h0;
        rst_n = 1'b0;

        // Reset state
        #2;
        chk({31'b0, a_ready}, 32'h0, "rst_a_ready");
        chk({31'b0, b_ready}, 32'h0, "rst_b_ready");
        chk(a_rd, 32'h0, "rst_a_rd");
        chk(b_rd, 32'h0, "rst_b_rd");
        step();
        step();
        rst_n = 1'b1;
        // No request: ready stays low, read data stays zero
        for (int i = 0; i < 3; i++) begin
            step();
            chk({31'b0, a_ready}, 32'h0, "idle_a_ready");
            chk(a_rd, 32'h0, "idle_a_rd");
        end

        // ---------------- LATENCY=2 instance ----------------
        xact(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, "a_wr10");
        xact(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, "a_rd10");
        xact(1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'hDEADBEEF, "a_wr20");
        xact(1'b0, 1'b1, 4'h1, 32'h20, 32'hFFFFFFAA, 32'hDEADBEEF, "a_wr20_b0");
        xact(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 32'h112233AA, "a_rd20");
        // be=0 still handshakes but changes nothing
        xact(1'b0, 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 32'h112233AA, "a_wr20_be0");
        xact(1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h112233AA, "a_rd20_be0");
        // Wrap and byte-offset ignore
        xact(1'b0, 1'b1, 4'hF, 32'h1000, 32'h00000055, 32'h112233AA, "a_wr1000");
        xact(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00000055, "a_rd0_wrap");
        xact(1'b0, 1'b0, 4'h0, 32'h13, 32'h0, 32'hDEADBEEF, "a_rd13");

        // Back-to-back: request held through DONE is taken in the next IDLE
        sel = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h10; req = 1'b1;
        step();
        chk({31'b0, ready}, 32'h0, "b2b_T+1");
        step();
        chk({31'b0, ready}, 32'h1, "b2b_T+2");
        chk(rd, 32'hDEADBEEF, "b2b_rd1");
        addr = 32'h20;
        step();
        chk({31'b0, ready}, 32'h0, "b2b_T+3");
        step();
        chk({31'b0, ready}, 32'h0, "b2b_T+4");
        step();
        chk({31'b0, ready}, 32'h1, "b2b_T+5");
        chk(rd, 32'h112233AA, "b2b_rd2");
        req = 1'b0;
        step();
        chk({31'b0, ready}, 32'h0, "b2b_T+6");

        // Mid-operation change: request dropped and fields altered in BUSY
        xact(1'b0, 1'b1, 4'hF, 32'h34, 32'h00000000, 32'h112233AA, "a_wr34");
        sel = 1'b0; we = 1'b1; be = 4'hF; addr = 32'h30; wd = 32'h77777777; req = 1'b1;
        step();
        req = 1'b0; addr = 32'h34; wd = 32'h99999999; be = 4'h0;
        chk({31'b0, ready}, 32'h0, "mid_T+1");
        step();
        chk({31'b0, ready}, 32'h1, "mid_T+2");
        step();
        chk({31'b0, ready}, 32'h0, "mid_T+3");
        xact(1'b0, 1'b0, 4'h0, 32'h30, 32'h0, 32'h77777777, "a_rd30");
        xact(1'b0, 1'b0, 4'h0, 32'h34, 32'h0, 32'h00000000, "a_rd34");

        // Reset while BUSY: the write is dropped, old data remains
        xact(1'b0, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 32'h00000000, "a_wr40");
        sel = 1'b0; we = 1'b1; be = 4'hF; addr = 32'h40; wd = 32'h12345678; req = 1'b1;
        step();
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({31'b0, a_ready}, 32'h0, "rstbusy_ready0");
        step();
        chk({31'b0, a_ready}, 32'h0, "rstbusy_ready1");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk({31'b0, a_ready}, 32'h0, "rstbusy_after");
        end
        xact(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, 32'hCAFEF00D, "a_rd40");

        // ---------------- LATENCY=1 instance ----------------
        xact(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, "b_wr10");
        xact(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, "b_rd10");
        xact(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, 32'hDEADBEEF, "b_wr20");
        xact(1'b1, 1'b1, 4'h1, 32'h20, 32'h000000AA, 32'hDEADBEEF, "b_wr20_b0");
        xact(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'h112233AA, "b_rd20");
        xact(1'b1, 1'b1, 4'hF, 32'h1000, 32'h00000055, 32'h112233AA, "b_wr1000");
        xact(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h00000055, "b_rd0_wrap");

        // Reset in DONE: write already committed on the accepting edge persists
        sel = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h40; wd = 32'hAAAA5555; req = 1'b1;
        step();
        chk({31'b0, b_ready}, 32'h1, "b_rstdone_ready");
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({31'b0, b_ready}, 32'h0, "b_rstdone_ready0");
        chk(b_rd, 32'h0, "b_rstdone_rd0");
        step();
        rst_n = 1'b1;
        step();
        chk({31'b0, b_ready}, 32'h0, "b_rstdone_after");
        xact(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 32'hAAAA5555, "b_rd40");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_lat_data_mem
